// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: receive-side buffer behind the SPI slave.
// Synchronises the slave's frame-complete flag into clk, captures one word
// per completed frame into a circular FIFO and presents it first-word-fall-
// through over valid/ready. A sticky overflow flag records dropped frames.
// Optional frame/drop statistics counters: define SPI_RX_STATS_EN.
module spi_rx_fifo #(
    parameter int DW          = 12,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done_in,
    input  logic [DW-1:0]                din,
    output logic [DW-1:0]                out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         overflow,
    input  logic                         clr_ovf
`ifdef SPI_RX_STATS_EN
    ,
    output logic [15:0]                  frame_cnt,
    output logic [15:0]                  drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_settle;
    logic                   r_prev;
    logic                   r_armed;
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;
    logic [DW-1:0]          r_mem [DEPTH];

    logic w_done_s;
    logic w_settled;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_drop;

    // The sync flops come out of reset at 0, so done_s only reflects the real
    // done_in once the chain has refilled. r_settle marks that point; arming
    // before it would mistake a done_in already high at reset for a new edge.
    assign w_done_s  = r_sync[SYNC_STAGES-1];
    assign w_settled = r_settle[SYNC_STAGES-1];

    assign w_push   = r_armed & w_done_s & ~r_prev;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);
    assign w_pop    = ~w_empty & out_ready;
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

    assign out_valid = ~w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];

    // Stage boundary: done_in synchroniser, edge history and arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_settle <= '0;
            r_prev   <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], done_in};
            r_settle <= {r_settle[SYNC_STAGES-2:0], 1'b1};
            r_prev   <= w_done_s;
            r_armed  <= r_armed | (w_settled & ~w_done_s);
        end
    end

    // Stage boundary: FIFO storage write (data path, not reset).
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Stage boundary: pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a fresh drop outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef SPI_RX_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_frame_cnt;
    logic [15:0] r_drop_cnt;

    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;

    // Saturating frame and drop statistics; untouched by clr_ovf.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_frame_cnt <= sat_inc16(r_frame_cnt);
            end
            if (w_drop) begin
                r_drop_cnt <= sat_inc16(r_drop_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb_spi_rx_fifo: directed, table-driven bench for spi_rx_fifo.
module tb_spi_rx_fifo;

    logic        clk;
    logic        rst;
    logic        done_in;
    logic [11:0] din;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic        full;
    logic        overflow;
    logic        clr_ovf;
`ifdef SPI_RX_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    spi_rx_fifo #(.DW(12), .DEPTH(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_in   (done_in),
        .din       (din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
`ifdef SPI_RX_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        logic [11:0] din;
        logic        rdy;
        logic        clr;
        logic        exp_valid;
        logic [11:0] exp_data;
        logic [3:0]  exp_count;
        logic        exp_full;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_data", out_data, 0);
`ifdef SPI_RX_STATS_EN
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
`endif
        rst = 1'b0;
        repeat (5) tick();
    endtask

    task automatic send_frame(input logic [11:0] d, input int hold);
        din     = d;
        done_in = 1'b1;
        repeat (hold) tick();
        done_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic pop_check(input string name, input logic [11:0] exp);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [11:0] q[$];
        logic [11:0] e;

        rst = 1'b1; done_in = 1'b0; din = '0; out_ready = 1'b0; clr_ovf = 1'b0;

        // Single frame: latency, FWFT head, pop, and a harmless clr_ovf.
        //               done din     rdy clr  vld data     cnt full ovf
        tbl[0] = '{1'b1, 12'hA5C, 1'b0, 1'b0, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 12'hA5C, 1'b0, 1'b0, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 12'hA5C, 1'b0, 1'b0, 1'b1, 12'hA5C, 4'd1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 12'hA5C, 1'b0, 1'b0, 1'b1, 12'hA5C, 4'd1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 12'hA5C, 1'b1, 1'b0, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 12'hA5C, 1'b1, 1'b0, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 12'hA5C, 1'b0, 1'b1, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 12'hA5C, 1'b0, 1'b0, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0};

        #1;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            done_in   = tbl[i].done;
            din       = tbl[i].din;
            out_ready = tbl[i].rdy;
            clr_ovf   = tbl[i].clr;
            tick();
            check($sformatf("vec%0d_valid", i), out_valid, tbl[i].exp_valid);
            check($sformatf("vec%0d_data", i), out_data, tbl[i].exp_data);
            check($sformatf("vec%0d_count", i), count, tbl[i].exp_count);
            check($sformatf("vec%0d_full", i), full, tbl[i].exp_full);
            check($sformatf("vec%0d_ovf", i), overflow, tbl[i].exp_ovf);
        end
        out_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) tick();

        // Long done pulse: one capture only.
        send_frame(12'h123, 22);
        repeat (3) tick();
        check("long_count", count, 1);
        pop_check("long_pop", 12'h123);
        check("long_empty", count, 0);

        // Reset released with done_in already high: that frame is ignored.
        rst = 1'b1; done_in = 1'b1; din = 12'hFFF;
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();
        check("rsthi_count_hi", count, 0);
        done_in = 1'b0;
        repeat (6) tick();
        check("rsthi_count_lo", count, 0);
        send_frame(12'h001, 3);
        check("rsthi_count", count, 1);
        pop_check("rsthi_pop", 12'h001);
        check("rsthi_empty", out_valid, 0);

        // Overflow: 9 frames into 8 entries, then drain in order.
        do_reset();
        for (int i = 0; i < 9; i++) send_frame(12'h100 + 12'(i), 3);
        check("ovf_count", count, 8);
        check("ovf_full", full, 1);
        check("ovf_flag", overflow, 1);
`ifdef SPI_RX_STATS_EN
        check("ovf_frame_cnt", frame_cnt, 9);
        check("ovf_drop_cnt", drop_cnt, 1);
`endif
        for (int i = 0; i < 8; i++) pop_check($sformatf("ovf_drain%0d", i), 12'h100 + 12'(i));
        check("ovf_drained", count, 0);
        check("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);
`ifdef SPI_RX_STATS_EN
        check("ovf_frame_kept", frame_cnt, 9);
`endif

        // Full FIFO with push and pop on the same edge.
        for (int i = 0; i < 8; i++) send_frame(12'h200 + 12'(i), 3);
        check("fpp_full_before", full, 1);
        check("fpp_head", out_data, 12'h200);
        din = 12'h208; done_in = 1'b1;
        tick();            // edge k: done_in sampled high
        tick();            // edge k+1
        out_ready = 1'b1;
        tick();            // edge k+2: push and pop together
        out_ready = 1'b0;
        done_in = 1'b0;
        repeat (4) tick();
        check("fpp_count", count, 8);
        check("fpp_ovf", overflow, 0);
        check("fpp_full", full, 1);
        for (int i = 1; i < 9; i++) pop_check($sformatf("fpp_drain%0d", i), 12'h200 + 12'(i));
        check("fpp_empty", count, 0);

        // Pointer wrap with interleaved drains, occupancy kept at 3 or below.
        for (int i = 0; i < 20; i++) begin
            send_frame(12'(i), 3);
            q.push_back(12'(i));
            if (q.size() == 3 || i == 19) begin
                check($sformatf("wrap_count%0d", i), count, 32'(q.size()));
                while (q.size() > 0) begin
                    e = q.pop_front();
                    pop_check($sformatf("wrap_word%0h", e), e);
                end
            end
        end
        check("wrap_end_count", count, 0);
        check("wrap_end_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_rx_fifo.md
Name: spi_rx_fifo

Overview:
Receive-side buffer directly downstream of the SPI slave. It synchronises the slave's frame-complete strobe into the system clock domain and captures each completed 12-bit word exactly once. Words are held in a circular FIFO and presented to the user through a first-word-fall-through valid/ready interface. Overflow is flagged when the consumer falls behind the SPI link.

Parameters:
DW, 12, data word width; must match the slave output word.
DEPTH, 8, FIFO entries; power of two, minimum 2.
SYNC_STAGES, 2, flops in the done synchroniser; minimum 2.

Ports:
clk  input  1  system clock.
rst  input  1  reset, synchronous, active-high.
done_in  input  1  slave frame-complete flag; sclk domain, treated as asynchronous.
din  input  DW  slave parallel word; stable while done_in is high.
out_data  output  DW  head-of-FIFO word; valid only when out_valid=1.
out_valid  output  1  FIFO not empty.
out_ready  input  1  consumer accepts; a pop occurs when out_valid and out_ready are both high.
count  output  $clog2(DEPTH+1)  current occupancy.
full  output  1  count==DEPTH.
overflow  output  1  sticky; a completed frame was dropped.
clr_ovf  input  1  clears overflow (single cycle).

Behaviour:
- Reset (clk edge with rst=1):
  - wr_ptr, rd_ptr, count = 0.
  - overflow = 0, full = 0, out_valid = 0.
  - out_data = 0 while empty.
  - Synchroniser flops and prev register = 0; armed = 0.
- Synchroniser: done_in passes through SYNC_STAGES flops to give done_s. The prev register holds done_s from the previous cycle.
- Arm: armed is set the first cycle done_s=0 after reset. This prevents a spurious capture when done_in is already high at reset release.
- Push event: push = armed & done_s & ~prev. This gives exactly one push per done_in rising edge, regardless of how long done is held (one sclk period, about 22 clk cycles).
- Latency (SYNC_STAGES=2): done_in first sampled high at edge k -> din written at edge k+2. With an empty FIFO, out_valid=1 and out_data=din after edge k+2.
- Pop: when out_valid & out_ready, rd_ptr advances at the clock edge. out_data is combinational from mem[rd_ptr] (FWFT).
- Pointers: log2(DEPTH) bits, wrap naturally DEPTH-1 -> 0. count is tracked separately.
- Simultaneous push and pop:
  - Not full: both occur; count unchanged.
  - Full: both occur; the word is accepted, count stays DEPTH, and overflow is not set.
  - Empty: push occurs, pop is ignored (out_valid=0), count becomes 1.
- Push while full without a pop: the word is dropped. Memory, pointers and count are unchanged; overflow<=1.
- Overflow flag: overflow stays 1 until rst, or a clk edge with clr_ovf=1. If clr_ovf and a new drop occur in the same cycle, the drop wins and overflow stays 1.
- Pop while empty: ignored; no pointer movement.
- Reset mid-operation: FIFO contents are discarded and armed=0. A frame whose done_in is high during reset is not captured.

Optional Feature:
Macro SPI_RX_STATS_EN.
- Defined: adds outputs frame_cnt[15:0] and drop_cnt[15:0].
  - frame_cnt increments on every push event, accepted or dropped.
  - drop_cnt increments on every dropped push.
  - Both saturate at 16'hFFFF and clear on rst.
  - clr_ovf does not clear them.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with done_in=0, then a single frame din=12'hA5C -> out_valid rises exactly 2 clk edges after done_in is sampled high. out_data=12'hA5C, count=1. out_ready=1 for one cycle -> count=0, out_valid=0.
- done_in held high for 22 clk cycles with din=12'h123 -> exactly one word captured; count=1, not 22.
- rst released while done_in=1 (din=12'hFFF), done_in later falls, then a frame 12'h001 -> only 12'h001 is captured.
- 9 frames 12'h100..12'h108 with out_ready=0 (DEPTH=8) -> full=1, overflow=1, count=8. Draining returns 12'h100..12'h107 in order; 12'h108 is absent. With SPI_RX_STATS_EN: frame_cnt=9, drop_cnt=1.
- FIFO full, push coincides with a pop -> out_data sequence continues with no loss; overflow remains 0, count=8.
- Pointer wrap: 20 frames 12'h000..12'h013 interleaved with pops, keeping count at 3 or below -> all 20 words read back in order; count=0 at the end.
